pwm_int_multi: RTL

//  Parametrised N-channel PWM generator with AXI4-Lite slave register file and per-channel

---
 rtl/pwm_int_pkg.sv | 29 ++
 rtl/pwm_int_multi_if.sv | 26 ++
 rtl/pwm_int_chan.sv | 77 +++++++
 rtl/pwm_int_multi.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pwm_int_pkg.sv
// Shared constants and types for the multi-channel PWM peripheral: register map,
// ID tag, AXI response codes, per-channel config view and FSM state types.
package pwm_int_pkg;
  localparam int REG_CTRL     = 0;
  localparam int REG_IRQ_EN   = 4;
  localparam int REG_IRQ_STAT = 8;
  localparam int REG_ID       = 12;
  localparam int CH_BASE      = 16;
  localparam int CH_STRIDE    = 16;
  localparam int CH_PERIOD    = 0;
  localparam int CH_DUTY      = 4;
  localparam int CH_COUNT     = 8;

  localparam logic [15:0] ID_TAG      = 16'h5057;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] duty;
  } ch_cfg_t;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
endpackage

// File: rtl/pwm_int_multi_if.sv
// AXI4-Lite slave bundle for pwm_int_multi; master drives requests, slave answers.
interface pwm_int_multi_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid, s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid, s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid, s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid, s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid, s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/pwm_int_chan.sv
// One PWM channel: period counter, duty compare, wrap pulse.
// PWM_SHADOW_EN: PERIOD/DUTY writes land in shadow regs and load on wrap.
module pwm_int_chan import pwm_int_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_period,
  input  logic             wr_duty,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] cnt,
  output ch_cfg_t          cfg_rd,
  output logic             pwm,
  output logic             wrap
);
  logic [CNT_W-1:0] period, duty;
  logic             run;

  assign run = en && (period != '0);
  // ">=" also catches a PERIOD shrunk below the running count
  assign wrap = run && (cnt >= period - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      pwm <= (cnt < duty);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [CNT_W-1:0] period_sh, duty_sh, period_nx, duty_nx;
  logic             load;

  assign period_nx = wr_period ? wdata : period_sh;
  assign duty_nx   = wr_duty   ? wdata : duty_sh;
  assign load      = wrap || !en || (period == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= '0;
      duty_sh   <= '0;
      period    <= '0;
      duty      <= '0;
    end else begin
      period_sh <= period_nx;
      duty_sh   <= duty_nx;
      if (load) begin
        period <= period_nx;
        duty   <= duty_nx;
      end
    end
  end

  assign cfg_rd.period = 32'(period_sh);
  assign cfg_rd.duty   = 32'(duty_sh);
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period <= '0;
      duty   <= '0;
    end else begin
      if (wr_period) period <= wdata;
      if (wr_duty)   duty   <= wdata;
    end
  end

  assign cfg_rd.period = 32'(period);
  assign cfg_rd.duty   = 32'(duty);
`endif
endmodule

// File: rtl/pwm_int_multi.sv
// N-channel PWM with AXI4-Lite register file and per-channel wrap interrupt.
// Optional build macro PWM_SHADOW_EN selects wrap-synchronous PERIOD/DUTY updates.
module pwm_int_multi import pwm_int_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  pwm_int_multi_if.slave       axi,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 irq
);
  logic [NUM_CH-1:0]            ctrl, irq_en, irq_stat, wrap;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt, ch_wdata;
  ch_cfg_t [NUM_CH-1:0]         cfg_rd;
  logic [NUM_CH-1:0]            wr_per, wr_duty;
  logic [ADDR_W-1:0]            wa, ra;
  logic [31:0]                  wmask, rd_val;
  logic                         wr_fire, ar_fire, wr_ok, rd_ok;
  logic                         sel_ctrl, sel_ien, sel_ist;
  wr_state_t                    wst, wst_nx;
  rd_state_t                    rst_q, rst_nx;

  assign wa    = axi.s_awaddr & ~ADDR_W'(3);
  assign ra    = axi.s_araddr & ~ADDR_W'(3);
  assign wmask = strb_mask(axi.s_wstrb);

  // Write channel: handshake only when both AW and W are present
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) wst <= W_IDLE;
    else        wst <= wst_nx;

  always_comb begin
    wst_nx       = wst;
    wr_fire      = 1'b0;
    axi.s_bvalid = (wst == W_RESP);
    case (wst)
      W_IDLE:  if (axi.s_awvalid && axi.s_wvalid && !ARESET) begin
                 wr_fire = 1'b1;
                 wst_nx  = W_RESP;
               end
      W_RESP:  if (axi.s_bready) wst_nx = W_IDLE;
      default: wst_nx = W_IDLE;
    endcase
  end

  assign axi.s_awready = wr_fire;
  assign axi.s_wready  = wr_fire;

  always_comb begin
    wr_ok    = 1'b0;
    sel_ctrl = 1'b0;
    sel_ien  = 1'b0;
    sel_ist  = 1'b0;
    wr_per   = '0;
    wr_duty  = '0;
    if (wa == ADDR_W'(REG_CTRL))     begin wr_ok = 1'b1; sel_ctrl = 1'b1; end
    if (wa == ADDR_W'(REG_IRQ_EN))   begin wr_ok = 1'b1; sel_ien  = 1'b1; end
    if (wa == ADDR_W'(REG_IRQ_STAT)) begin wr_ok = 1'b1; sel_ist  = 1'b1; end
    for (int c = 0; c < NUM_CH; c++) begin
      if (wa == ADDR_W'(CH_BASE + CH_STRIDE*c + CH_PERIOD)) begin
        wr_ok     = 1'b1;
        wr_per[c] = wr_fire;
      end
      if (wa == ADDR_W'(CH_BASE + CH_STRIDE*c + CH_DUTY)) begin
        wr_ok      = 1'b1;
        wr_duty[c] = wr_fire;
      end
    end
  end

  // Register file; a wrap outranks a same-cycle W1C of its status bit
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl        <= '0;
      irq_en      <= '0;
      irq_stat    <= '0;
      irq         <= 1'b0;
      axi.s_bresp <= RESP_OKAY;
    end else begin
      if (wr_fire && sel_ctrl)
        ctrl <= NUM_CH'((32'(ctrl) & ~wmask) | (axi.s_wdata & wmask));
      if (wr_fire && sel_ien)
        irq_en <= NUM_CH'((32'(irq_en) & ~wmask) | (axi.s_wdata & wmask));
      irq_stat <= (irq_stat & ~((wr_fire && sel_ist) ? NUM_CH'(axi.s_wdata & wmask) : '0)) | wrap;
      irq      <= |(irq_stat & irq_en);
      if (wr_fire) axi.s_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Read channel
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) rst_q <= R_IDLE;
    else        rst_q <= rst_nx;

  always_comb begin
    rst_nx       = rst_q;
    ar_fire      = 1'b0;
    axi.s_rvalid = (rst_q == R_DATA);
    case (rst_q)
      R_IDLE:  if (axi.s_arvalid && !ARESET) begin
                 ar_fire = 1'b1;
                 rst_nx  = R_DATA;
               end
      R_DATA:  if (axi.s_rready) rst_nx = R_IDLE;
      default: rst_nx = R_IDLE;
    endcase
  end

  assign axi.s_arready = ar_fire;

  always_comb begin
    rd_ok  = 1'b1;
    rd_val = '0;
    if      (ra == ADDR_W'(REG_CTRL))     rd_val = 32'(ctrl);
    else if (ra == ADDR_W'(REG_IRQ_EN))   rd_val = 32'(irq_en);
    else if (ra == ADDR_W'(REG_IRQ_STAT)) rd_val = 32'(irq_stat);
    else if (ra == ADDR_W'(REG_ID))       rd_val = {ID_TAG, 8'(NUM_CH), 8'(CNT_W)};
    else                                  rd_ok  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ra == ADDR_W'(CH_BASE + CH_STRIDE*c + CH_PERIOD)) begin rd_ok = 1'b1; rd_val = cfg_rd[c].period; end
      if (ra == ADDR_W'(CH_BASE + CH_STRIDE*c + CH_DUTY))   begin rd_ok = 1'b1; rd_val = cfg_rd[c].duty;   end
      if (ra == ADDR_W'(CH_BASE + CH_STRIDE*c + CH_COUNT))  begin rd_ok = 1'b1; rd_val = 32'(cnt[c]);      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      axi.s_rdata <= '0;
      axi.s_rresp <= RESP_OKAY;
    end else if (ar_fire) begin
      axi.s_rdata <= rd_val;
      axi.s_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Byte-strobe merge against the readable (shadow or active) value
    assign ch_wdata[c] = wr_per[c]
      ? CNT_W'((cfg_rd[c].period & ~wmask) | (axi.s_wdata & wmask))
      : CNT_W'((cfg_rd[c].duty   & ~wmask) | (axi.s_wdata & wmask));

    pwm_int_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (ACLK),
      .rst       (ARESET),
      .en        (ctrl[c]),
      .wr_period (wr_per[c]),
      .wr_duty   (wr_duty[c]),
      .wdata     (ch_wdata[c]),
      .cnt       (cnt[c]),
      .cfg_rd    (cfg_rd[c]),
      .pwm       (pwm_out[c]),
      .wrap      (wrap[c])
    );
  end
endmodule
